// File: rtl/sram_tdp_be_pipe.sv
// rtl/sram_tdp_be_pipe.sv - true dual-port byte-enable SRAM model with pipelined, write-first reads
// Optional collision flag output enabled by defining SRAM_COLLISION_FLAG_EN.
module sram_tdp_be_pipe #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8192,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int BE_W   = DATA_W / 8,
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic [BE_W-1:0]   wea,
    input  logic [ADDR_W-1:0] addra,
    input  logic [DATA_W-1:0] dina,
    output logic [DATA_W-1:0] douta,
    output logic              rvalida,
    input  logic              enb,
    input  logic [BE_W-1:0]   web,
    input  logic [ADDR_W-1:0] addrb,
    input  logic [DATA_W-1:0] dinb,
    output logic [DATA_W-1:0] doutb,
    output logic              rvalidb
`ifdef SRAM_COLLISION_FLAG_EN
    ,
    output logic              coll
`endif
);

    if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_lat
        $error("sram_tdp_be_pipe: RD_LAT must be in 1..4");
    end
    if (DATA_W % 8 != 0) begin : g_bad_width
        $error("sram_tdp_be_pipe: DATA_W must be a multiple of 8");
    end

    logic [DATA_W-1:0] mem [DEPTH];

    logic              en     [2];
    logic [BE_W-1:0]   we     [2];
    logic [ADDR_W-1:0] addr   [2];
    logic [DATA_W-1:0] din    [2];
    logic              in_rng [2];
    logic [BE_W-1:0]   wr_be  [2];
    logic [DATA_W-1:0] word   [2];
    logic              same_addr;

    logic [RD_LAT-1:0] pv_q [2];
    logic [RD_LAT-1:0] pv_d [2];
    logic [DATA_W-1:0] pd_q [2][RD_LAT];
    logic [DATA_W-1:0] pd_d [2][RD_LAT];
    logic [DATA_W-1:0] dout_q   [2];
    logic [DATA_W-1:0] dout_d   [2];
    logic              rvalid_q [2];
    logic              rvalid_d [2];

    always_comb begin
        en[0]   = ena;
        we[0]   = wea;
        addr[0] = addra;
        din[0]  = dina;
        en[1]   = enb;
        we[1]   = web;
        addr[1] = addrb;
        din[1]  = dinb;
    end

    // word[p] is the post-edge content at addr[p]: B bytes merged first so A wins shared bytes.
    always_comb begin
        same_addr = (addra == addrb);
        for (int p = 0; p < 2; p++) begin
            in_rng[p] = ({1'b0, addr[p]} < (ADDR_W + 1)'(DEPTH));
            wr_be[p]  = (rst_n && en[p] && in_rng[p]) ? we[p] : '0;
        end
        for (int p = 0; p < 2; p++) begin
            word[p] = in_rng[p] ? mem[addr[p]] : '0;
            for (int i = 0; i < BE_W; i++) begin
                if (wr_be[1][i] && (p == 1 || same_addr)) word[p][8*i +: 8] = din[1][8*i +: 8];
            end
            for (int i = 0; i < BE_W; i++) begin
                if (wr_be[0][i] && (p == 0 || same_addr)) word[p][8*i +: 8] = din[0][8*i +: 8];
            end
        end
    end

    // Array is deliberately not reset so contents survive rst_n.
    always_ff @(posedge clk) begin
        for (int p = 0; p < 2; p++) begin
            if (|wr_be[p]) mem[addr[p]] <= word[p];
        end
    end

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            pv_d[p]    = '0;
            pv_d[p][0] = en[p];
            pd_d[p][0] = en[p] ? word[p] : pd_q[p][0];
            for (int k = 1; k < RD_LAT; k++) begin
                pv_d[p][k] = pv_q[p][k-1];
                pd_d[p][k] = pd_q[p][k-1];
            end
            rvalid_d[p] = pv_q[p][RD_LAT-1];
            dout_d[p]   = pv_q[p][RD_LAT-1] ? pd_q[p][RD_LAT-1] : dout_q[p];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int p = 0; p < 2; p++) begin
                pv_q[p]     <= '0;
                dout_q[p]   <= '0;
                rvalid_q[p] <= 1'b0;
                for (int k = 0; k < RD_LAT; k++) pd_q[p][k] <= '0;
            end
        end else begin
            for (int p = 0; p < 2; p++) begin
                pv_q[p]     <= pv_d[p];
                dout_q[p]   <= dout_d[p];
                rvalid_q[p] <= rvalid_d[p];
                for (int k = 0; k < RD_LAT; k++) pd_q[p][k] <= pd_d[p][k];
            end
        end
    end

    assign douta   = dout_q[0];
    assign rvalida = rvalid_q[0];
    assign doutb   = dout_q[1];
    assign rvalidb = rvalid_q[1];

`ifdef SRAM_COLLISION_FLAG_EN
    logic coll_q;
    logic coll_d;

    always_comb begin
        coll_d = ena && enb && same_addr && (|wea || |web);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) coll_q <= 1'b0;
        else        coll_q <= coll_d;
    end

    assign coll = coll_q;
`endif

endmodule

// File: tb/tb_sram_tdp_be_pipe.sv
// tb/tb_sram_tdp_be_pipe.sv - randomized scoreboard bench for sram_tdp_be_pipe
// Three instances (RD_LAT 2/DEPTH 8192, RD_LAT 1/DEPTH 200, RD_LAT 4/DEPTH 200) share one stimulus.
module tb_sram_tdp_be_pipe;

    logic        clk;
    logic        rst_n;
    logic        ena, enb;
    logic [3:0]  wea, web;
    logic [12:0] addra, addrb;
    logic [31:0] dina, dinb;
    logic [31:0] dout_a [3];
    logic [31:0] dout_b [3];
    logic        rv_a   [3];
    logic        rv_b   [3];
`ifdef SRAM_COLLISION_FLAG_EN
    logic        coll_o [3];
`endif

    typedef struct {
        int          due;
        logic [31:0] d;
    } rd_t;

    logic [31:0] mm   [3][256];
    rd_t         rq   [3][2][$];
    logic [31:0] hold [3][2];
    logic        coll_exp;
    int          ecnt;
    int          n_checks;
    int          n_errors;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    sram_tdp_be_pipe #(.RD_LAT(2)) u_dut_l2 (
        .clk(clk), .rst_n(rst_n),
        .ena(ena), .wea(wea), .addra(addra), .dina(dina), .douta(dout_a[0]), .rvalida(rv_a[0]),
        .enb(enb), .web(web), .addrb(addrb), .dinb(dinb), .doutb(dout_b[0]), .rvalidb(rv_b[0])
`ifdef SRAM_COLLISION_FLAG_EN
        , .coll(coll_o[0])
`endif
    );

    sram_tdp_be_pipe #(.DEPTH(200), .RD_LAT(1)) u_dut_l1 (
        .clk(clk), .rst_n(rst_n),
        .ena(ena), .wea(wea), .addra(addra[7:0]), .dina(dina), .douta(dout_a[1]), .rvalida(rv_a[1]),
        .enb(enb), .web(web), .addrb(addrb[7:0]), .dinb(dinb), .doutb(dout_b[1]), .rvalidb(rv_b[1])
`ifdef SRAM_COLLISION_FLAG_EN
        , .coll(coll_o[1])
`endif
    );

    sram_tdp_be_pipe #(.DEPTH(200), .RD_LAT(4)) u_dut_l4 (
        .clk(clk), .rst_n(rst_n),
        .ena(ena), .wea(wea), .addra(addra[7:0]), .dina(dina), .douta(dout_a[2]), .rvalida(rv_a[2]),
        .enb(enb), .web(web), .addrb(addrb[7:0]), .dinb(dinb), .doutb(dout_b[2]), .rvalidb(rv_b[2])
`ifdef SRAM_COLLISION_FLAG_EN
        , .coll(coll_o[2])
`endif
    );

    function automatic int lat_of(input int i);
        return (i == 0) ? 2 : (i == 1) ? 1 : 4;
    endfunction

    function automatic int depth_of(input int i);
        return (i == 0) ? 8192 : 200;
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic a_en, input logic [3:0] a_we, input logic [7:0] a_ad, input logic [31:0] a_d,
                         input logic b_en, input logic [3:0] b_we, input logic [7:0] b_ad, input logic [31:0] b_d);
        ena = a_en; wea = a_we; addra = {5'b0, a_ad}; dina = a_d;
        enb = b_en; web = b_we; addrb = {5'b0, b_ad}; dinb = b_d;
    endtask

    task automatic drive_idle();
        drive(1'b0, 4'h0, 8'h0, 32'h0, 1'b0, 4'h0, 8'h0, 32'h0);
    endtask

    task automatic drive_random();
        logic [7:0] aa, ab;
        aa = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 15)) : 8'($urandom_range(0, 255));
        ab = ($urandom_range(0, 2) == 0) ? aa : 8'($urandom_range(0, 255));
        drive(($urandom_range(0, 9) < 7), ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 15)) : 4'h0, aa, $urandom,
              ($urandom_range(0, 9) < 7), ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 15)) : 4'h0, ab, $urandom);
    endtask

    // Reference: apply B then A byte writes to the word array, then every accepted request reads the result.
    task automatic model_edge();
        logic [31:0] v;
        ecnt++;
        coll_exp = 1'b0;
        if (rst_n !== 1'b1) return;
        coll_exp = ena && enb && (addra == addrb) && (|wea || |web);
        for (int i = 0; i < 3; i++) begin
            if (enb && int'(addrb) < depth_of(i))
                for (int k = 0; k < 4; k++) if (web[k]) mm[i][addrb[7:0]][8*k +: 8] = dinb[8*k +: 8];
            if (ena && int'(addra) < depth_of(i))
                for (int k = 0; k < 4; k++) if (wea[k]) mm[i][addra[7:0]][8*k +: 8] = dina[8*k +: 8];
        end
        for (int i = 0; i < 3; i++) begin
            if (ena) begin
                v = (int'(addra) < depth_of(i)) ? mm[i][addra[7:0]] : 32'h0;
                rq[i][0].push_back('{due: ecnt + lat_of(i), d: v});
            end
            if (enb) begin
                v = (int'(addrb) < depth_of(i)) ? mm[i][addrb[7:0]] : 32'h0;
                rq[i][1].push_back('{due: ecnt + lat_of(i), d: v});
            end
        end
    endtask

    task automatic check_outputs();
        logic exp_rv;
        for (int i = 0; i < 3; i++) begin
            for (int p = 0; p < 2; p++) begin
                exp_rv = 1'b0;
                if (rq[i][p].size() > 0 && rq[i][p][0].due == ecnt) begin
                    exp_rv     = 1'b1;
                    hold[i][p] = rq[i][p][0].d;
                    void'(rq[i][p].pop_front());
                end
                check_val($sformatf("rvalid_l%0d_%s@%0d", lat_of(i), (p == 0) ? "a" : "b", ecnt),
                          {31'b0, (p == 0) ? rv_a[i] : rv_b[i]}, {31'b0, exp_rv});
                check_val($sformatf("dout_l%0d_%s@%0d", lat_of(i), (p == 0) ? "a" : "b", ecnt),
                          (p == 0) ? dout_a[i] : dout_b[i], hold[i][p]);
            end
`ifdef SRAM_COLLISION_FLAG_EN
            check_val($sformatf("coll_l%0d@%0d", lat_of(i), ecnt), {31'b0, coll_o[i]}, {31'b0, coll_exp});
`endif
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic idle_steps(input int n);
        drive_idle();
        repeat (n) step();
    endtask

    task automatic reset_mid(input int cycles);
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            for (int p = 0; p < 2; p++) begin
                rq[i][p].delete();
                hold[i][p] = 32'h0;
            end
        end
        coll_exp = 1'b0;
        check_outputs();
        repeat (cycles) begin
            drive_random();
            step();
        end
        #2 rst_n = 1'b1;
    endtask

    task automatic check_held(input string tag, input logic is_b, input logic [31:0] e0, input logic [31:0] e12);
        check_val({tag, "_l2"}, is_b ? dout_b[0] : dout_a[0], e0);
        check_val({tag, "_l1"}, is_b ? dout_b[1] : dout_a[1], e12);
        check_val({tag, "_l4"}, is_b ? dout_b[2] : dout_a[2], e12);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        ecnt     = 0;
        coll_exp = 1'b0;
        for (int i = 0; i < 3; i++)
            for (int p = 0; p < 2; p++) hold[i][p] = 32'h0;
        drive_idle();
        rst_n = 1'b0;
        #1;
        check_outputs();
        repeat (3) step();
        #2 rst_n = 1'b1;

        for (int a = 0; a < 256; a++) begin
            drive(1'b0, 4'h0, 8'h0, 32'h0, 1'b1, 4'hF, 8'(a), $urandom);
            step();
        end
        idle_steps(6);

        drive(1'b1, 4'hF, 8'd5, 32'hDEADBEEF, 1'b0, 4'h0, 8'd0, 32'h0); step();
        drive(1'b1, 4'h0, 8'd5, 32'h0, 1'b0, 4'h0, 8'd0, 32'h0); step();
        idle_steps(6);
        check_held("hold_deadbeef", 1'b0, 32'hDEADBEEF, 32'hDEADBEEF);

        drive(1'b1, 4'hF, 8'd7, 32'h11223344, 1'b0, 4'h0, 8'd0, 32'h0); step();
        drive(1'b1, 4'h5, 8'd7, 32'hAABBCCDD, 1'b0, 4'h0, 8'd0, 32'h0); step();
        drive(1'b1, 4'h0, 8'd7, 32'h0, 1'b0, 4'h0, 8'd0, 32'h0); step();
        idle_steps(6);
        check_held("byte_en", 1'b0, 32'h11BB33DD, 32'h11BB33DD);

        drive(1'b1, 4'h1, 8'd9, 32'h000000FF, 1'b1, 4'hF, 8'd9, 32'h12345678); step();
        idle_steps(6);
        check_held("coll_a", 1'b0, 32'h123456FF, 32'h123456FF);
        check_held("coll_b", 1'b1, 32'h123456FF, 32'h123456FF);

        for (int a = 0; a < 8; a++) begin
            drive(1'b0, 4'h0, 8'd0, 32'h0, 1'b1, 4'h0, 8'(a), 32'h0);
            step();
        end
        idle_steps(6);
        check_held("b2b_last", 1'b1, 32'h11BB33DD, 32'h11BB33DD);

        drive(1'b1, 4'h0, 8'd1, 32'h0, 1'b1, 4'h0, 8'd2, 32'h0); step();
        drive(1'b1, 4'h0, 8'd3, 32'h0, 1'b1, 4'h0, 8'd4, 32'h0); step();
        reset_mid(3);
        idle_steps(6);

        drive(1'b1, 4'hF, 8'd250, 32'hCAFE0250, 1'b0, 4'h0, 8'd0, 32'h0); step();
        drive(1'b1, 4'h0, 8'd250, 32'h0, 1'b0, 4'h0, 8'd0, 32'h0); step();
        idle_steps(6);
        check_held("oor_250", 1'b0, 32'hCAFE0250, 32'h0);

        for (int n = 0; n < 2000; n++) begin
            if (n == 1000) reset_mid(2);
            drive_random();
            step();
        end
        idle_steps(6);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
